// File: rtl/switch_io_conditioner_pkg.sv
// Shared IO unit types: level-update mode, level FSM states and default level geometry.
package IO_UnitTypes;
  typedef enum logic {DIRECT = 1'b0, STEP = 1'b1} AxLevelMode;
  typedef enum logic {IDLE = 1'b0, HOLDOFF = 1'b1} level_state_e;

  localparam int AX_LEVEL_WIDTH_DEF = 8;
  localparam int LEVEL_SHIFT_DEF    = 2;
endpackage

// File: rtl/switch_io_conditioner_debouncer.sv
// Multi-flop synchronizer followed by a per-channel mismatch-counting debouncer.
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             negResetIn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (!negResetIn) begin
      sync <= '0;
    end else begin
      sync[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          bit_q;

    // Counter tops out at DEBOUNCE_CYCLES-1, where the bit flips and the count restarts.
    always_ff @(posedge clk) begin
      if (!negResetIn) begin
        cnt   <= '0;
        bit_q <= 1'b0;
      end else if (sync[SYNC_STAGES-1][g] == bit_q) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        bit_q <= ~bit_q;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign db[g] = bit_q;
  end
endmodule

// File: rtl/switch_io_conditioner.sv
// Conditions raw gaze/push switches and drives an approximation level with edge lockout.
module switch_io_conditioner
  import IO_UnitTypes::*;
#(
  parameter int SW_WIDTH        = 8,
  parameter int PSW_WIDTH       = 5,
  parameter int AX_LEVEL_WIDTH  = AX_LEVEL_WIDTH_DEF,
  parameter int LEVEL_SHIFT     = LEVEL_SHIFT_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 64,
  parameter int STEP_MODE       = 0
) (
  input  logic                      clk,
  input  logic                      negResetIn,
  input  logic [SW_WIDTH-1:0]       swIn,
  input  logic [PSW_WIDTH-1:0]      pswIn,
  output logic [SW_WIDTH-1:0]       gazeOut,
  output logic                      gazeChanged,
  output logic [AX_LEVEL_WIDTH-1:0] axLevelData,
  output logic                      axLevelEn
);
  localparam AxLevelMode MODE = (STEP_MODE != 0) ? STEP : DIRECT;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [AX_LEVEL_WIDTH-1:0] STEP_SZ = AX_LEVEL_WIDTH'(1) << LEVEL_SHIFT;
  localparam logic [AX_LEVEL_WIDTH-1:0] MAX_AL  = {AX_LEVEL_WIDTH{1'b1}} << LEVEL_SHIFT;

  logic [SW_WIDTH-1:0]       gaze_prev;
  logic [PSW_WIDTH-1:0]      psw_db, psw_prev, rise;
  level_state_e              state, state_n;
  logic [HW-1:0]             hcnt, hcnt_n;
  logic [AX_LEVEL_WIDTH-1:0] level_n, direct_val;
  logic                      en_n, hold_done;

  switch_debouncer #(.WIDTH(SW_WIDTH), .SYNC_STAGES(SYNC_STAGES),
                     .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk(clk), .negResetIn(negResetIn), .raw(swIn), .db(gazeOut));

  switch_debouncer #(.WIDTH(PSW_WIDTH), .SYNC_STAGES(SYNC_STAGES),
                     .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_psw_db (
    .clk(clk), .negResetIn(negResetIn), .raw(pswIn), .db(psw_db));

  assign gazeChanged = (gazeOut != gaze_prev);
  assign rise        = psw_db & ~psw_prev;
  // Upper push switches form the level's high field; bits beyond the level width drop off.
  assign direct_val  = AX_LEVEL_WIDTH'(psw_db >> 1) << LEVEL_SHIFT;
  assign hold_done   = (HOLDOFF_CYCLES <= 1) || (hcnt == HW'(HOLDOFF_CYCLES - 1));

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    level_n = axLevelData;
    en_n    = 1'b0;
    case (state)
      IDLE: begin
        if (MODE == DIRECT) begin
          if (rise[0]) begin
            level_n = direct_val;
            en_n    = 1'b1;
          end
        end else if (rise[1] != rise[2]) begin
          en_n = 1'b1;
          if (rise[1]) level_n = (axLevelData >= MAX_AL - STEP_SZ) ? MAX_AL : axLevelData + STEP_SZ;
          else         level_n = (axLevelData <= STEP_SZ) ? '0 : axLevelData - STEP_SZ;
        end
        if (en_n) begin
          state_n = HOLDOFF;
          hcnt_n  = '0;
        end
      end
      HOLDOFF: begin
        if (hold_done) state_n = IDLE;
        else           hcnt_n  = hcnt + HW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!negResetIn) begin
      state       <= IDLE;
      hcnt        <= '0;
      axLevelData <= '0;
      axLevelEn   <= 1'b0;
      psw_prev    <= '0;
      gaze_prev   <= '0;
    end else begin
      state       <= state_n;
      hcnt        <= hcnt_n;
      axLevelData <= level_n;
      axLevelEn   <= en_n;
      psw_prev    <= psw_db;
      gaze_prev   <= gazeOut;
    end
  end
endmodule

// File: tb/tb_switch_io_conditioner.sv
// Bench: a direct-mode and a step-mode conditioner fed the same switches.
module tb_switch_io_conditioner;
  localparam int S = 2, D = 4, H = 32, ROW = 48;

  logic       clk = 1'b0, negResetIn = 1'b0;
  logic [7:0] swIn = '0;
  logic [4:0] pswIn = '0;
  logic [7:0] gaze_d, gaze_s, lvl_d, lvl_s;
  logic       chg_d, chg_s, en_d, en_s;
  int checks = 0, passed = 0;
  int n_chg = 0, n_en_d = 0, n_en_s = 0;

  always #5 clk = ~clk;

  switch_io_conditioner #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .STEP_MODE(0)) u_dir (
    .clk(clk), .negResetIn(negResetIn), .swIn(swIn), .pswIn(pswIn),
    .gazeOut(gaze_d), .gazeChanged(chg_d), .axLevelData(lvl_d), .axLevelEn(en_d));

  switch_io_conditioner #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .STEP_MODE(1)) u_step (
    .clk(clk), .negResetIn(negResetIn), .swIn(swIn), .pswIn(pswIn),
    .gazeOut(gaze_s), .gazeChanged(chg_s), .axLevelData(lvl_s), .axLevelEn(en_s));

  always @(negedge clk) begin
    if (chg_d) n_chg++;
    if (en_d)  n_en_d++;
    if (en_s)  n_en_s++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    negResetIn = 1'b0;
    repeat (3) tick();
    negResetIn = 1'b1;
  endtask

  // Reference: a debounced bit flips once the raw value seen S+D-1..S cycles ago
  // disagreed with it on all D of those samples.
  logic [7:0] q_sw[$];
  logic [4:0] q_psw[$];
  logic [7:0] m_gaze;
  logic       m_chg;
  logic [4:0] m_psw, m_psw_old;
  int         m_lvl[2], m_hold[2];
  logic       m_en[2];

  task automatic model_reset();
    q_sw.delete(); q_psw.delete();
    repeat (S + D) begin q_sw.push_back('0); q_psw.push_back('0); end
    m_gaze = '0; m_chg = 1'b0; m_psw = '0; m_psw_old = '0;
    for (int m = 0; m < 2; m++) begin m_lvl[m] = 0; m_hold[m] = 0; m_en[m] = 1'b0; end
  endtask

  task automatic model_edge(input logic [7:0] sw, input logic [4:0] psw);
    logic [7:0] g_new;
    logic [4:0] p_new, rise;
    logic       all;
    int         dval;
    q_sw.push_back(sw);   void'(q_sw.pop_front());
    q_psw.push_back(psw); void'(q_psw.pop_front());
    rise = m_psw & ~m_psw_old;
    dval = ((int'(m_psw) >> 1) * 4) % 256;
    g_new = m_gaze;
    for (int b = 0; b < 8; b++) begin
      all = 1'b1;
      for (int i = 0; i < D; i++) if (q_sw[i][b] == m_gaze[b]) all = 1'b0;
      if (all) g_new[b] = ~m_gaze[b];
    end
    p_new = m_psw;
    for (int b = 0; b < 5; b++) begin
      all = 1'b1;
      for (int i = 0; i < D; i++) if (q_psw[i][b] == m_psw[b]) all = 1'b0;
      if (all) p_new[b] = ~m_psw[b];
    end
    m_chg = (g_new != m_gaze);
    m_gaze = g_new;
    m_psw_old = m_psw;
    m_psw = p_new;
    for (int m = 0; m < 2; m++) begin
      m_en[m] = 1'b0;
      if (m_hold[m] > 0) m_hold[m]--;
      else if (m == 0 && rise[0]) begin
        m_lvl[0] = dval; m_en[0] = 1'b1;
      end else if (m == 1 && rise[1] != rise[2]) begin
        m_lvl[1] = rise[1] ? ((m_lvl[1] + 4 > 252) ? 252 : m_lvl[1] + 4)
                           : ((m_lvl[1] < 4) ? 0 : m_lvl[1] - 4);
        m_en[1] = 1'b1;
      end
      if (m_en[m]) m_hold[m] = (H < 1) ? 1 : H;
    end
  endtask

  typedef struct {
    logic [7:0] sw;
    logic [4:0] psw;
    logic [7:0] gaze;
    logic [7:0] lvl_dir;
    logic [7:0] lvl_step;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, e0, lat, lat_en;
    tbl[0] = '{8'hA5, 5'b00000, 8'hA5, 8'h00, 8'h00};
    tbl[1] = '{8'h3C, 5'b01011, 8'h3C, 8'h14, 8'h04};
    tbl[2] = '{8'h3C, 5'b11111, 8'h3C, 8'h14, 8'h00};
    tbl[3] = '{8'hFF, 5'b11110, 8'hFF, 8'h14, 8'h00};
    tbl[4] = '{8'h00, 5'b11111, 8'h00, 8'h3C, 8'h00};
    tbl[5] = '{8'h81, 5'b00001, 8'h81, 8'h3C, 8'h00};
    tbl[6] = '{8'h81, 5'b00000, 8'h81, 8'h3C, 8'h00};
    tbl[7] = '{8'h7E, 5'b10011, 8'h7E, 8'h24, 8'h04};

    do_reset();
    check("reset gaze", gaze_d, 0);
    check("reset chg", chg_d, 0);
    check("reset lvl dir", lvl_d, 0);
    check("reset en dir", en_d, 0);
    check("reset lvl step", lvl_s, 0);

    // 0x00 -> 0xA5: latency S+D and a single change pulse
    n0 = n_chg; lat = -1; swIn = 8'hA5;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (lat < 0 && gaze_d == 8'hA5) lat = i;
    end
    check("gaze latency", lat, S + D);
    check("gaze pulses", n_chg - n0, 1);

    // bit0 bouncing every 2 cycles never gets accepted
    n0 = n_chg;
    for (int i = 0; i < 10; i++) begin swIn = swIn ^ 8'h01; tick(); tick(); end
    repeat (10) tick();
    check("bounce gaze", gaze_d, 8'hA5);
    check("bounce pulses", n_chg - n0, 0);

    for (int r = 0; r < 8; r++) begin
      swIn = tbl[r].sw; pswIn = tbl[r].psw;
      repeat (ROW) tick();
      check($sformatf("tbl%0d gaze", r), gaze_d, tbl[r].gaze);
      check($sformatf("tbl%0d lvl dir", r), lvl_d, tbl[r].lvl_dir);
      check($sformatf("tbl%0d lvl step", r), lvl_s, tbl[r].lvl_step);
    end

    // direct load, then a second psw[0] edge inside the lockout is dropped
    swIn = '0; pswIn = '0; do_reset();
    e0 = n_en_d; pswIn = 5'b01011;
    repeat (12) tick();
    pswIn = 5'b01010; repeat (8) tick();
    pswIn = 5'b01111; repeat (40) tick();
    check("holdoff lvl dir", lvl_d, 8'h14);
    check("holdoff en dir", n_en_d - e0, 1);

    // simultaneous up/down edges are ignored
    pswIn = '0; do_reset();
    pswIn = 5'b00010; repeat (ROW) tick();
    pswIn = 5'b00000; repeat (ROW) tick();
    check("step up", lvl_s, 8'h04);
    e0 = n_en_s; pswIn = 5'b00110; repeat (ROW) tick();
    check("both lvl", lvl_s, 8'h04);
    check("both en", n_en_s - e0, 0);

    // climb to the top, saturate, then step down
    pswIn = '0; do_reset();
    for (int k = 0; k < 63; k++) begin
      pswIn = 5'b00010; repeat (8) tick();
      pswIn = 5'b00000; repeat (40) tick();
    end
    check("climb lvl", lvl_s, 8'hFC);
    e0 = n_en_s;
    pswIn = 5'b00010; repeat (8) tick();
    pswIn = 5'b00000; repeat (40) tick();
    check("sat lvl", lvl_s, 8'hFC);
    check("sat en", n_en_s - e0, 1);
    pswIn = 5'b00100; repeat (8) tick();
    check("down lvl", lvl_s, 8'hF8);
    check("down en", n_en_s - e0, 2);
    pswIn = '0; repeat (40) tick();

    // reset during lockout and mid-debounce leaves nothing behind
    do_reset();
    pswIn = 5'b00001;
    for (int i = 0; i < 12 && !en_d; i++) tick();
    check("mid en seen", en_d, 1);
    swIn = 8'hFF; repeat (4) tick();
    n0 = n_chg; e0 = n_en_d;
    negResetIn = 1'b0; swIn = '0; pswIn = '0;
    repeat (2) tick();
    negResetIn = 1'b1;
    repeat (20) tick();
    check("mid gaze", gaze_d, 0);
    check("mid lvl", lvl_d, 0);
    check("mid chg pulses", n_chg - n0, 0);
    check("mid en pulses", n_en_d - e0, 0);

    // inputs high through reset
    swIn = 8'hFF; pswIn = 5'b11111;
    negResetIn = 1'b0; repeat (3) tick();
    negResetIn = 1'b1; e0 = n_en_s;
    tick();
    check("rel gaze", gaze_d, 0);
    check("rel chg", chg_d, 0);
    check("rel en", en_d, 0);
    lat = -1; lat_en = -1;
    for (int i = 2; i <= 12; i++) begin
      tick();
      if (lat < 0 && gaze_d == 8'hFF) lat = i;
      if (lat_en < 0 && en_d) lat_en = i;
    end
    check("rel gaze latency", lat, S + D);
    check("rel en latency", lat_en, S + D + 1);
    check("rel lvl dir", lvl_d, 8'h3C);
    check("rel step en", n_en_s - e0, 0);

    // randomized run against the reference
    swIn = '0; pswIn = '0; do_reset(); model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) swIn = swIn ^ 8'($urandom);
      if ($urandom_range(0, 9) == 0) pswIn = pswIn ^ 5'($urandom_range(1, 31));
      @(posedge clk);
      model_edge(swIn, pswIn);
      #1;
      check("rnd gaze", gaze_d, m_gaze);
      check("rnd gaze step", gaze_s, m_gaze);
      check("rnd chg", chg_d, m_chg);
      check("rnd chg step", chg_s, m_chg);
      check("rnd lvl dir", lvl_d, m_lvl[0]);
      check("rnd en dir", en_d, m_en[0]);
      check("rnd lvl step", lvl_s, m_lvl[1]);
      check("rnd en step", en_s, m_en[1]);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/switch_io_conditioner.md
SWITCH_IO_CONDITIONER -- requirements
Module: switch_io_conditioner

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- SW_WIDTH, 8, gaze switch channel count
- PSW_WIDTH, 5, push-switch channel count (>=3)
- AX_LEVEL_WIDTH, 8, approximation-level width
- LEVEL_SHIFT, 2, zero LSBs appended to the level
- SYNC_STAGES, 2, synchronizer depth (>=2)
- DEBOUNCE_CYCLES, 16, stable cycles before accepting a change (>=1)
- HOLDOFF_CYCLES, 64, post-update edge lockout
- STEP_MODE, 0, 0 = direct load, 1 = up/down step.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock
- negResetIn, in, 1, synchronous active-low reset
- swIn, in, SW_WIDTH, raw asynchronous gaze switches
- pswIn, in, PSW_WIDTH, raw asynchronous push switches
- gazeOut, out, SW_WIDTH, debounced gaze value
- gazeChanged, out, 1, one-cycle pulse when gazeOut changes
- axLevelData, out, AX_LEVEL_WIDTH, current level
- axLevelEn, out, 1, one-cycle pulse when axLevelData is updated.
REQ-003 There SHALL be one clock; reset SHALL be synchronous and active-low.

Function
REQ-004 Every input bit SHALL pass through a SYNC_STAGES-flop synchronizer.
REQ-005 Each channel SHALL keep a debounced bit and a mismatch counter; the counter increments while the synchronized bit differs from the debounced bit and clears on any cycle they match.
REQ-006 The debounced bit SHALL flip, and the counter SHALL clear, on the edge where the mismatch persists for DEBOUNCE_CYCLES consecutive cycles; raw-to-debounced latency is exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles.
REQ-007 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) and SHALL never wrap.
REQ-008 gazeOut SHALL equal the debounced swIn; gazeChanged SHALL pulse for the one cycle in which gazeOut differs from its previous value.
REQ-009 In direct mode (STEP_MODE=0), a debounced rising edge of psw[0] SHALL load axLevelData with psw[AX_LEVEL_WIDTH-LEVEL_SHIFT:1] concatenated with LEVEL_SHIFT zeros, and axLevelEn SHALL pulse in the same cycle.
REQ-010 In step mode (STEP_MODE=1), a debounced rising edge of psw[1] SHALL add 1<<LEVEL_SHIFT and a rising edge of psw[2] SHALL subtract 1<<LEVEL_SHIFT, saturating at max-aligned and 0 respectively; psw[0] SHALL be ignored.
REQ-011 In step mode, simultaneous psw[1] and psw[2] edges SHALL leave the level unchanged and SHALL NOT pulse axLevelEn.
REQ-012 An update that saturates without changing the value SHALL still pulse axLevelEn.
REQ-013 The level FSM SHALL have the states IDLE and HOLDOFF:
- IDLE: on an accepted edge, perform the update and go to HOLDOFF.
- HOLDOFF: ignore level edges for HOLDOFF_CYCLES cycles, then return to IDLE.
- HOLDOFF_CYCLES=0 means return to IDLE after one cycle.
REQ-014 Edges arriving during HOLDOFF SHALL be discarded, not queued.
REQ-015 Edge detection SHALL operate on debounced values only.

Reset
REQ-016 While negResetIn=0 at a clock edge, the following SHALL clear to 0: synchronizers, debounced bits, counters, edge-history registers, gazeOut, gazeChanged, axLevelData and axLevelEn; the FSM SHALL go to IDLE.
REQ-017 No edge or change pulse SHALL be produced in the first cycle after reset release, even if inputs are already high.
REQ-018 Reset asserted mid-debounce or mid-HOLDOFF SHALL abandon that operation with no pulse.

Structure
REQ-019 The AxLevelMode enum (DIRECT, STEP) and the default AX_LEVEL_WIDTH/LEVEL_SHIFT constants SHALL live in the shared IO_UnitTypes package.
REQ-020 Synchronizer plus debounce SHALL be one sub-module, switch_debouncer, parametrised by width, and instantiated once for swIn and once for pswIn.

Verification
REQ-021 Defaults with DEBOUNCE_CYCLES=4: swIn 0x00->0xA5 held -> gazeOut=0xA5 exactly 6 cycles later, gazeChanged pulses once.
REQ-022 swIn bit0 toggling every 2 cycles for 20 cycles, DEBOUNCE_CYCLES=4 -> gazeOut never changes, no gazeChanged.
REQ-023 Direct mode, pswIn=5'b01011 held -> axLevelData=8'h14 and one axLevelEn pulse; a second psw[0] edge within HOLDOFF -> no change.
REQ-024 Step mode, level 8'hFC, psw[1] edge -> stays 8'hFC with axLevelEn; psw[2] edge after HOLDOFF -> 8'hF8.
REQ-025 Step mode, psw[1] and psw[2] rise together -> level unchanged, no axLevelEn.
REQ-026 Inputs high through reset, release -> outputs 0 for the first cycle; gazeOut and pswIn edges appear after 2+DEBOUNCE_CYCLES cycles.
